// File: rtl/bcd_to_bin.sv
// bcd_to_bin
//   Converts a three-digit BCD number (000..999) to a 10-bit binary value
//   using reverse double-dabble, one iteration per clock, 12 iterations.
//   An invalid digit (> 9) skips the conversion and reports ERR_CODE.
//
// Ports
//   Clk      in   system clock, all state updates on the rising edge
//   Rst_n    in   asynchronous active-low reset
//   Start    in   conversion request, sampled only while idle
//   Hundreds in   BCD hundreds digit
//   Tens     in   BCD tens digit
//   Ones     in   BCD ones digit
//   Binary   out  converted value, or ERR_CODE for an invalid digit
//   Busy     out  high while iterations are in progress
//   Done     out  one-cycle pulse marking a new Binary/Error result
//   Error    out  high when the last result came from an invalid digit
module bcd_to_bin #(
    parameter logic [9:0] ERR_CODE = 10'h3FF
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic [3:0] Hundreds,
    input  logic [3:0] Tens,
    input  logic [3:0] Ones,
    output logic [9:0] Binary,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [11:0] bcd_q,    bcd_d;
    logic [11:0] bin_q,    bin_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [9:0]  binary_q, binary_d;
    logic        error_q,  error_d;

    logic [23:0] shifted;
    logic [11:0] bcd_adj;
    logic        digit_bad;

    // A nibble whose MSB was just filled by the digit above it holds
    // value + 8 where it should hold value + 5 (half of ten): take 3 off.
    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    assign shifted   = {bcd_q, bin_q} >> 1;
    assign bcd_adj   = {adj3(shifted[23:20]), adj3(shifted[19:16]), adj3(shifted[15:12])};
    assign digit_bad = (Hundreds > 4'd9) || (Tens > 4'd9) || (Ones > 4'd9);

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    bcd_d = {Hundreds, Tens, Ones};
                    if (digit_bad) begin
                        binary_d = ERR_CODE;
                        error_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        bin_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = shifted[11:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    // Final iteration: publish the freshly shifted value.
                    binary_d = shifted[9:0];
                    error_d  = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            error_q  <= error_d;
        end
    end

    assign Binary = binary_q;
    assign Error  = error_q;
    assign Busy   = (state_q == S_SHIFT);
    assign Done   = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin
//   Self-checking bench for bcd_to_bin. Expected {Error, Binary} pairs are
//   queued when a conversion is requested and retired on every Done pulse.
module tb_bcd_to_bin;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [3:0] Hundreds = '0;
    logic [3:0] Tens = '0;
    logic [3:0] Ones = '0;
    logic [9:0] Binary;
    logic       Busy;
    logic       Done;
    logic       Error;

    int         n_vec = 0;
    int         n_err = 0;
    logic [10:0] sb[$];
    logic [10:0] exp_r;

    always #5 Clk = ~Clk;

    bcd_to_bin #(.ERR_CODE(10'h3FF)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Hundreds (Hundreds),
        .Tens     (Tens),
        .Ones     (Ones),
        .Binary   (Binary),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error)
    );

    // Scoreboard: every Done pulse retires the oldest expected result.
    always @(negedge Clk) begin
        if (Rst_n && Done) begin
            n_vec++;
            if (Busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_done_overlap: Busy=%b required 0", Busy);
            end
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: Binary=%h Error=%b, no result pending", Binary, Error);
            end else begin
                exp_r = sb.pop_front();
                if ({Error, Binary} !== exp_r)  begin
                    n_err++;
                    $display("FAIL scoreboard: Error/Binary=%b/%h required %b/%h",
                             Error, Binary, exp_r[10], exp_r[9:0]);
                end
            end
        end
    end

    task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                            input logic [9:0] exp_bin, input logic exp_err, input int exp_lat,
                            input string name);
        int k;
        @(negedge Clk);
        Hundreds = h; Tens = t; Ones = o; Start = 1'b1;
        sb.push_back({exp_err, exp_bin});
        @(negedge Clk);
        Start = 1'b0;
        k = 0;
        while (!Done && k < 40) begin
            n_vec++;
            if (Busy !== (exp_lat != 0)) begin
                n_err++;
                $display("FAIL %s_busy: Busy=%b at cycle %0d required %b", name, Busy, k, exp_lat != 0);
            end
            @(negedge Clk);
            k++;
        end
        n_vec++;
        if (!Done) begin
            n_err++;
            $display("FAIL %s_timeout: no Done within 40 cycles", name);
        end else if (k != exp_lat) begin
            n_err++;
            $display("FAIL %s_latency: Done after %0d cycles required %0d", name, k, exp_lat);
        end
        n_vec++;
        if (Binary !== exp_bin || Error !== exp_err) begin
            n_err++;
            $display("FAIL %s_result: Binary=%h Error=%b required %h %b", name, Binary, Error, exp_bin, exp_err);
        end
        @(negedge Clk);
        n_vec++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after: Done=%b Busy=%b required 0 0", name, Done, Busy);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        n_vec++;
        if (Binary !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: Binary=%h Busy=%b Done=%b Error=%b required 0 0 0 0",
                     Binary, Busy, Done, Error);
        end
        Rst_n = 1'b1;
    endtask

    task automatic test_values;
        run_conv(4'd0, 4'd0, 4'd0, 10'd0, 1'b0, 12, "zero");
        run_conv(4'd9, 4'd9, 4'd9, 10'h3E7, 1'b0, 12, "max999");
        repeat (3) @(negedge Clk);
        n_vec++;
        if (Binary !== 10'h3E7 || Error !== 1'b0) begin
            n_err++;
            $display("FAIL hold_result: Binary=%h Error=%b required 3e7 0", Binary, Error);
        end
        run_conv(4'd1, 4'd2, 4'd8, 10'd128, 1'b0, 12, "v128");
    endtask

    task automatic test_invalid;
        run_conv(4'd3, 4'd10, 4'd5, 10'h3FF, 1'b1, 0, "bad_tens");
        run_conv(4'd15, 4'd0, 4'd0, 10'h3FF, 1'b1, 0, "bad_hund");
        run_conv(4'd0, 4'd0, 4'd1, 10'd1, 1'b0, 12, "err_clear");
    endtask

    task automatic test_ignore_start;
        int k;
        @(negedge Clk);
        Hundreds = 4'd4; Tens = 4'd5; Ones = 4'd6; Start = 1'b1;
        sb.push_back({1'b0, 10'd456});
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Hundreds = 4'd7; Tens = 4'd7; Ones = 4'd7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        k = 5;
        while (!Done && k < 40) begin
            @(negedge Clk);
            k++;
        end
        n_vec++;
        if (k != 12) begin
            n_err++;
            $display("FAIL ignore_latency: Done after %0d cycles required 12", k);
        end
        n_vec++;
        if (Binary !== 10'd456) begin
            n_err++;
            $display("FAIL ignore_result: Binary=%0d required 456", Binary);
        end
        repeat (20) @(negedge Clk);
        n_vec++;
        if (sb.size() != 0 || Binary !== 10'd456) begin
            n_err++;
            $display("FAIL ignore_extra: pending=%0d Binary=%0d required 0 456", sb.size(), Binary);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        @(negedge Clk);
        Hundreds = 4'd1; Tens = 4'd2; Ones = 4'd3; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        n_vec++;
        if (Binary !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: Binary=%h Busy=%b Done=%b Error=%b required 0 0 0 0",
                     Binary, Busy, Done, Error);
        end
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort_no_done: %0d Done pulses required 0", dones);
        end
        run_conv(4'd0, 4'd4, 4'd2, 10'd42, 1'b0, 12, "after_abort");
    endtask

    task automatic test_back_to_back;
        int  nxt;
        int  dones;
        int  cyc;
        int  last_done;
        logic prev_busy;
        @(negedge Clk);
        Hundreds = 4'd0; Tens = 4'd0; Ones = 4'd0; Start = 1'b1;
        sb.push_back({1'b0, 10'd0});
        nxt = 1; dones = 0; cyc = 0; last_done = -1; prev_busy = Busy;
        while (dones < 1000 && cyc < 15000) begin
            @(negedge Clk);
            cyc++;
            if (Busy && !prev_busy && nxt < 1000) begin
                Hundreds = 4'(nxt / 100);
                Tens     = 4'((nxt / 10) % 10);
                Ones     = 4'(nxt % 10);
                sb.push_back({1'b0, 10'(nxt)});
                nxt++;
            end
            prev_busy = Busy;
            if (Done) begin
                dones++;
                if (last_done >= 0) begin
                    n_vec++;
                    if (cyc - last_done != 14) begin
                        n_err++;
                        $display("FAIL sweep_spacing: Done gap %0d cycles at result %0d required 14",
                                 cyc - last_done, dones);
                    end
                end
                last_done = cyc;
            end
        end
        Start = 1'b0;
        n_vec++;
        if (dones != 1000) begin
            n_err++;
            $display("FAIL sweep_count: %0d results required 1000", dones);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_invalid();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        repeat (5) @(negedge Clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_results: %0d outstanding required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL provide parameter ERR_CODE, default 10'h3FF, value driven on Binary when an input digit is invalid.
REQ-002 SHALL provide port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port Rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port Start  input  1  request to convert the presented digits; sampled only in IDLE.
REQ-005 SHALL provide port Hundreds  input  4  BCD hundreds digit; valid range 0..9.
REQ-006 SHALL provide port Tens  input  4  BCD tens digit; valid range 0..9.
REQ-007 SHALL provide port Ones  input  4  BCD ones digit; valid range 0..9.
REQ-008 SHALL provide port Binary  output  10  converted value, 0..999, or ERR_CODE.
REQ-009 SHALL provide port Busy  output  1  high while a conversion is in progress.
REQ-010 SHALL provide port Done  output  1  one-cycle pulse marking a new Binary/Error result.
REQ-011 SHALL provide port Error  output  1  high when the last result came from an invalid digit.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-013 In IDLE with Start=1 at edge E0, SHALL capture all three digits into a 12-bit BCD register.
REQ-014 At E0, if any digit exceeds 9, SHALL go to DONE with Binary=ERR_CODE and Error=1, skipping SHIFT.
REQ-015 At E0, if all digits are valid, SHALL go to SHIFT, clear the 12-bit binary shift register and iteration counter, and set Busy=1.
REQ-016 In SHIFT, each edge SHALL perform one reverse double-dabble iteration.
- Shift {BCD, bin} right by one; the BCD LSB enters the bin MSB.
- Then subtract 3 from each BCD nibble that is >= 8.
REQ-017 SHALL perform exactly 12 iterations, on edges E1..E12.
REQ-018 At E12, SHALL load Binary with the low 10 bits of the bin register, clear Error, clear Busy and enter DONE.
REQ-019 In DONE, Done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE with Done=0.
REQ-020 Latency: Done SHALL be high 12 cycles after the Start edge for valid input, and 0 cycles after it (E0..E1) for invalid input.
REQ-021 Binary and Error SHALL hold their values from one Done pulse until the next Done pulse.
REQ-022 Start SHALL be ignored in SHIFT and DONE; a request is not queued and digit changes there have no effect.
REQ-023 Start held high continuously SHALL start a new conversion on each IDLE cycle, giving back-to-back operation every 14 cycles.
REQ-024 Busy and Done SHALL never be high in the same cycle.

Reset
REQ-025 Rst_n=0 SHALL immediately force IDLE, with Binary=0, Busy=0, Done=0, Error=0, and clear the counter and shift registers.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion with no Done pulse.
REQ-027 After Rst_n deasserts, the first Start edge SHALL behave exactly as in REQ-013.

Verification
REQ-028 Reset, then Start with 0,0,0 -> Done at E12, Binary=0, Error=0; Busy high E0..E12.
REQ-029 Start with 9,9,9 -> Binary=999 (10'h3E7) with the Done pulse at E12; Start with 1,2,8 -> Binary=128.
REQ-030 Start with 3,10,5 -> Done at E0..E1, Binary=10'h3FF, Error=1, Busy never asserted.
REQ-031 Start with 4,5,6, then pulse Start with 7,7,7 at E5 -> only 456 is produced, with a single Done pulse.
REQ-032 Rst_n low at E6 of a conversion -> all outputs 0, no Done; a following Start with 0,4,2 -> Binary=42.
REQ-033 Sweep all 1000 valid codes with Start held high -> each result equals 100*H+10*T+O, with Done spaced 14 cycles apart.
